// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of the single RAM port between instruction fetch (m0) and data (m1),
// with in-order response routing and locally generated error responses for off-window accesses.
module ram_port_arbiter #(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   DW       = 32,
    parameter int unsigned   SW       = 4,
    parameter logic [AW-1:0] RAM_BASE = AW'(32'h4000),
    parameter logic [AW-1:0] RAM_SIZE = AW'(32'h4000),
    parameter int unsigned   MAX_OUT  = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [SW-1:0] m0_be_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    output logic          m0_err_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [SW-1:0] m1_be_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic          m1_err_o,
    output logic          ram_req_o,
    output logic          ram_we_o,
    output logic [SW-1:0] ram_be_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic          ram_rvalid_i,
    input  logic [DW-1:0] ram_rdata_i
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    typedef enum logic { M0 = 1'b0, M1 = 1'b1 } owner_e;

    owner_e        prio_q, prio_d;
    owner_e        owner_q [MAX_OUT];
    owner_e        owner_d [MAX_OUT];
    logic [CW-1:0] count_q, count_d;
    logic          err_vld_q, err_vld_d;
    owner_e        err_own_q, err_own_d;

    logic [AW-1:0] off0, off1;
    logic          in0, in1, elig0, elig1;
    logic          fifo_empty, fifo_room;
    logic          any_gnt, sel_in, push, pop;
    owner_e        sel, head;

    always_comb begin
        off0       = m0_addr_i - RAM_BASE;
        off1       = m1_addr_i - RAM_BASE;
        in0        = off0 < RAM_SIZE;
        in1        = off1 < RAM_SIZE;
        fifo_empty = (count_q == '0);
        fifo_room  = (count_q < CW'(MAX_OUT));
        // Error grants wait for an empty FIFO so error responses stay in order.
        elig0      = rst_ni && m0_req_i && (in0 ? fifo_room : fifo_empty);
        elig1      = rst_ni && m1_req_i && (in1 ? fifo_room : fifo_empty);
        if (elig0 && elig1) begin
            sel = prio_q;
        end else if (elig1) begin
            sel = M1;
        end else begin
            sel = M0;
        end
        any_gnt = elig0 || elig1;
        sel_in  = (sel == M1) ? in1 : in0;
        push    = any_gnt && sel_in;
        pop     = ram_rvalid_i && !fifo_empty;
        head    = owner_q[0];
    end

    always_comb begin
        m0_gnt_o    = any_gnt && (sel == M0);
        m1_gnt_o    = any_gnt && (sel == M1);
        ram_req_o   = push;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (push) begin
            if (sel == M1) begin
                ram_we_o    = m1_we_i;
                ram_be_o    = m1_be_i;
                ram_addr_o  = off1;
                ram_wdata_o = m1_wdata_i;
            end else begin
                ram_we_o    = m0_we_i;
                ram_be_o    = m0_be_i;
                ram_addr_o  = off0;
                ram_wdata_o = m0_wdata_i;
            end
        end
        m0_rvalid_o = (pop && head == M0) || (err_vld_q && err_own_q == M0);
        m1_rvalid_o = (pop && head == M1) || (err_vld_q && err_own_q == M1);
        m0_err_o    = err_vld_q && err_own_q == M0;
        m1_err_o    = err_vld_q && err_own_q == M1;
        m0_rdata_o  = (pop && head == M0) ? ram_rdata_i : '0;
        m1_rdata_o  = (pop && head == M1) ? ram_rdata_i : '0;
    end

    always_comb begin
        prio_d  = prio_q;
        count_d = count_q;
        owner_d = owner_q;
        if (any_gnt) begin
            prio_d = (sel == M0) ? M1 : M0;
        end
        // Pop shifts the queue down first so a same-cycle push lands behind the new tail.
        if (pop) begin
            for (int unsigned i = 0; i + 1 < MAX_OUT; i++) begin
                owner_d[i] = owner_q[i + 1];
            end
            count_d = count_d - CW'(1);
        end
        if (push) begin
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                if (CW'(i) == count_d) begin
                    owner_d[i] = sel;
                end
            end
            count_d = count_d + CW'(1);
        end
        err_vld_d = any_gnt && !sel_in;
        err_own_d = sel;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q    <= M1;
            count_q   <= '0;
            err_vld_q <= 1'b0;
            err_own_q <= M0;
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                owner_q[i] <= M0;
            end
        end else begin
            prio_q    <= prio_d;
            count_q   <= count_d;
            err_vld_q <= err_vld_d;
            err_own_q <= err_own_d;
            owner_q   <= owner_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && ram_rvalid_i) begin
            assert (!fifo_empty)
            else $warning("ram_rvalid_i with no outstanding transaction ignored");
        end
    end

endmodule
